// File: rtl/bcd_key_entry.sv
// Debounced 10-key BCD entry: one digit per press/release, shifted into a decimal
// register that is shown on a scanned, multiplexed 7-segment display.
module bcd_key_entry #(
    parameter int DIGITS   = 4,
    parameter int DEBOUNCE = 16,
    parameter int SCAN_DIV = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   code,
    input  logic                         clr,
    output logic [4*DIGITS-1:0]          value,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         strobe,
    output logic [6:0]                   seg,
    output logic [DIGITS-1:0]            dig
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = $clog2(DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int NW = $clog2(DEBOUNCE);

    typedef enum logic [1:0] {RELEASED, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cand_q, cand_d;
    logic [NW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [CW-1:0]       count_q, count_d;
    logic                strobe_q, strobe_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                valid;
    logic                accept;
    logic [3:0]          nibble;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    always_comb begin
        valid   = (code <= 4'd9);
        accept  = (state_q == PRESS_CHK) && (code == cand_q) && (cnt_q == NW'(DEBOUNCE - 1));
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (valid) begin
                    state_d = PRESS_CHK;
                    cand_d  = code;
                    cnt_d   = NW'(1);
                end
            end
            PRESS_CHK: begin
                if (code != cand_q)
                    state_d = RELEASED;
                else if (accept)
                    state_d = HELD;
                else
                    cnt_d = cnt_q + NW'(1);
            end
            HELD: begin
                // Other valid codes while held are ignored: no key rollover.
                if (!valid) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = NW'(1);
                end
            end
            RELEASE_CHK: begin
                if (valid)
                    state_d = HELD;
                else if (cnt_q == NW'(DEBOUNCE - 1))
                    state_d = RELEASED;
                else
                    cnt_d = cnt_q + NW'(1);
            end
            default: state_d = HELD;
        endcase

        // Clear overrides a coincident accept; the FSM still moves to HELD.
        value_d  = value_q;
        count_d  = count_q;
        strobe_d = 1'b0;
        if (clr) begin
            value_d = '0;
            count_d = '0;
        end else if (accept) begin
            value_d  = {value_q[4*DIGITS-5:0], cand_q};
            strobe_d = 1'b1;
            if (count_q != CW'(DIGITS))
                count_d = count_q + CW'(1);
        end

        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        nibble = value_q[{idx_q, 2'b00} +: 4];
        dig_d  = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
        seg_d  = (32'(idx_q) < 32'(count_q)) ? decode(nibble) : 7'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HELD;
            cand_q   <= '0;
            cnt_q    <= '0;
            value_q  <= '0;
            count_q  <= '0;
            strobe_q <= 1'b0;
            presc_q  <= '0;
            idx_q    <= '0;
            seg_q    <= '0;
            dig_q    <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            count_q  <= count_d;
            strobe_q <= strobe_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
        end
    end

    assign value  = value_q;
    assign count  = count_q;
    assign strobe = strobe_q;
    assign seg    = seg_q;
    assign dig    = dig_q;
endmodule

// File: tb/tb_bcd_key_entry.sv
// Directed bench for bcd_key_entry with DEBOUNCE=4, SCAN_DIV=3, DIGITS=4.
module tb_bcd_key_entry;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  code = 4'd15;
    logic        clr = 1'b0;
    logic [15:0] value;
    logic [2:0]  count;
    logic        strobe;
    logic [6:0]  seg;
    logic [3:0]  dig;

    int compares = 0;
    int failures = 0;
    int strobe_total = 0;

    bcd_key_entry #(.DIGITS(4), .DEBOUNCE(4), .SCAN_DIV(3)) dut (
        .clk(clk), .rst(rst), .code(code), .clr(clr),
        .value(value), .count(count), .strobe(strobe), .seg(seg), .dig(dig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        int          cycles;
        logic [15:0] exp_value;
        logic [2:0]  exp_count;
        logic        exp_strobe;
        int          exp_total;
    } vec_t;

    vec_t vecs[20];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compares++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Outputs are sampled 1 time unit after each rising edge; strobes are tallied here.
    task automatic tick();
        @(posedge clk);
        #1;
        if (strobe) strobe_total++;
    endtask

    task automatic apply_stimulus(input logic [3:0] c, input int n);
        code = c;
        repeat (n) tick();
    endtask

    task automatic check_all_zero(input string name);
        check_output({name, "_value"}, 32'(value), 32'h0);
        check_output({name, "_count"}, 32'(count), 32'h0);
        check_output({name, "_strobe"}, 32'(strobe), 32'h0);
        check_output({name, "_seg"}, 32'(seg), 32'h0);
        check_output({name, "_dig"}, 32'(dig), 32'h0);
    endtask

    initial begin
        logic [6:0] exp_seg [4];
        int n;
        int base_total;
        exp_seg = '{7'h5B, 7'h66, 7'h00, 7'h00};

        vecs[0]  = '{4'd15, 4,  16'h0000, 3'd0, 1'b0, 0};
        vecs[1]  = '{4'd7,  4,  16'h0007, 3'd1, 1'b1, 1};
        vecs[2]  = '{4'd15, 4,  16'h0007, 3'd1, 1'b0, 1};
        vecs[3]  = '{4'd3,  2,  16'h0007, 3'd1, 1'b0, 1};
        vecs[4]  = '{4'd15, 1,  16'h0007, 3'd1, 1'b0, 1};
        vecs[5]  = '{4'd3,  4,  16'h0073, 3'd2, 1'b1, 2};
        vecs[6]  = '{4'd15, 4,  16'h0073, 3'd2, 1'b0, 2};
        vecs[7]  = '{4'd1,  4,  16'h0731, 3'd3, 1'b1, 3};
        vecs[8]  = '{4'd15, 4,  16'h0731, 3'd3, 1'b0, 3};
        vecs[9]  = '{4'd2,  4,  16'h7312, 3'd4, 1'b1, 4};
        vecs[10] = '{4'd15, 4,  16'h7312, 3'd4, 1'b0, 4};
        vecs[11] = '{4'd3,  4,  16'h3123, 3'd4, 1'b1, 5};
        vecs[12] = '{4'd15, 4,  16'h3123, 3'd4, 1'b0, 5};
        vecs[13] = '{4'd4,  4,  16'h1234, 3'd4, 1'b1, 6};
        vecs[14] = '{4'd15, 4,  16'h1234, 3'd4, 1'b0, 6};
        vecs[15] = '{4'd5,  4,  16'h2345, 3'd4, 1'b1, 7};
        vecs[16] = '{4'd15, 4,  16'h2345, 3'd4, 1'b0, 7};
        vecs[17] = '{4'd9,  50, 16'h3459, 3'd4, 1'b0, 8};
        vecs[18] = '{4'd8,  10, 16'h3459, 3'd4, 1'b0, 8};
        vecs[19] = '{4'd15, 4,  16'h3459, 3'd4, 1'b0, 8};

        #1;
        check_all_zero("reset");
        #3 rst = 1'b0;

        // Entry, glitch rejection, overflow and no-rollover sequences.
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(vecs[i].code, vecs[i].cycles);
            check_output($sformatf("vec%0d_value", i), 32'(value), 32'(vecs[i].exp_value));
            check_output($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check_output($sformatf("vec%0d_strobe", i), 32'(strobe), 32'(vecs[i].exp_strobe));
            check_output($sformatf("vec%0d_total", i), strobe_total, vecs[i].exp_total);
        end

        // Clear on the accept edge drops the digit; the key must be released first.
        apply_stimulus(4'd6, 3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_output("clr_accept_value", 32'(value), 32'h0);
        check_output("clr_accept_count", 32'(count), 32'h0);
        check_output("clr_accept_strobe", 32'(strobe), 32'h0);
        check_output("clr_accept_total", strobe_total, 8);
        apply_stimulus(4'd6, 4);
        check_output("clr_still_held_total", strobe_total, 8);
        apply_stimulus(4'd15, 4);
        apply_stimulus(4'd6, 4);
        check_output("clr_repress_value", 32'(value), 32'h6);
        check_output("clr_repress_count", 32'(count), 32'h1);
        check_output("clr_repress_total", strobe_total, 9);
        apply_stimulus(4'd15, 4);

        // Build 0x0042 and watch two full display scans.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        apply_stimulus(4'd4, 4);
        apply_stimulus(4'd15, 4);
        apply_stimulus(4'd2, 4);
        apply_stimulus(4'd15, 4);
        check_output("scan_value", 32'(value), 32'h42);
        check_output("scan_count", 32'(count), 32'h2);
        n = 0;
        while (dig !== 4'b1000 && n < 50) begin tick(); n++; end
        n = 0;
        while (dig !== 4'b0001 && n < 50) begin tick(); n++; end
        check_output("scan_sync", 32'(dig), 32'h1);
        for (int k = 0; k < 24; k++) begin
            check_output($sformatf("scan%0d_dig", k), 32'(dig), 32'(4'b0001 << ((k / 3) % 4)));
            check_output($sformatf("scan%0d_seg", k), 32'(seg), 32'(exp_seg[(k / 3) % 4]));
            tick();
        end

        // Asynchronous reset in the middle of a press check with key 5 held.
        base_total = strobe_total;
        apply_stimulus(4'd5, 2);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midreset");
        #2 rst = 1'b0;
        apply_stimulus(4'd5, 8);
        check_output("midreset_held_value", 32'(value), 32'h0);
        check_output("midreset_held_total", strobe_total, base_total);
        apply_stimulus(4'd15, 4);
        apply_stimulus(4'd5, 4);
        check_output("midreset_repress_value", 32'(value), 32'h5);
        check_output("midreset_repress_count", 32'(count), 32'h1);
        check_output("midreset_repress_total", strobe_total, base_total + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", compares, failures);
        $finish;
    end
endmodule
